// File: rtl/regfile_write_arbiter.sv
// Round-robin write-port arbiter that owns the register file decoder and data.
// Define REGFILE_ARB_CLEAR_EN to add a clear sweep that zeroes every register.
module regfile_write_arbiter #(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned ZERO_REG = 31
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*5-1:0]       req_addr,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         req_ready,
    input  logic                    clear_start,
    output logic [4:0]              dec_in,
    output logic                    dec_en,
    output logic [WIDTH-1:0]        wr_data,
    output logic                    busy
);

    localparam int unsigned AW    = 5;
    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SUM_W = PTR_W + 1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_vld;
    logic             run_ok;
    logic             transfer;
    logic [AW-1:0]    sel_addr;
    logic [WIDTH-1:0] sel_data;
    logic [AW-1:0]    dec_in_q, dec_in_d;
    logic             dec_en_q, dec_en_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;

`ifdef REGFILE_ARB_CLEAR_EN
    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    // Sweep skips the hardwired-zero register at either end of the range.
    localparam logic [AW-1:0] FIRST_ADDR = (ZERO_REG == 0)  ? AW'(1)  : AW'(0);
    localparam logic [AW-1:0] LAST_ADDR  = (ZERO_REG == 31) ? AW'(30) : AW'(31);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] cnt_inc;
    logic          busy_q, busy_d;

    assign run_ok = (state_q == S_RUN) && !clear_start;
    assign busy   = busy_q;
`else
    logic unused_clear_start;

    assign unused_clear_start = clear_start;
    assign run_ok             = 1'b1;
    assign busy               = 1'b0;
`endif

    // First valid requester at or after the round-robin pointer, wrapping at NREQ.
    always_comb begin : rr_search
        logic [SUM_W-1:0] pos;
        grant_vld = 1'b0;
        grant_idx = '0;
        pos       = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            pos = SUM_W'(ptr_q) + SUM_W'(k);
            if (pos >= SUM_W'(NREQ)) begin
                pos = pos - SUM_W'(NREQ);
            end
            if (!grant_vld && req_valid[pos[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = pos[PTR_W-1:0];
            end
        end
    end

    assign transfer = grant_vld && run_ok;
    assign sel_addr = req_addr[AW*32'(grant_idx) +: AW];
    assign sel_data = req_data[WIDTH*32'(grant_idx) +: WIDTH];

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // Next-state: accepted writes first, then the clear FSM overrides when present.
    always_comb begin
        ptr_d     = ptr_q;
        dec_in_d  = dec_in_q;
        dec_en_d  = 1'b0;
        wr_data_d = wr_data_q;
`ifdef REGFILE_ARB_CLEAR_EN
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        cnt_inc   = cnt_q + AW'(1);
        if (cnt_inc == ZERO_ADDR) begin
            cnt_inc = cnt_q + AW'(2);
        end
`endif

        if (transfer) begin
            dec_in_d  = sel_addr;
            wr_data_d = sel_data;
            dec_en_d  = (sel_addr != ZERO_ADDR);
            ptr_d     = (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + PTR_W'(1);
        end

`ifdef REGFILE_ARB_CLEAR_EN
        case (state_q)
            S_CLEAR: begin
                if (clear_start) begin
                    cnt_d = FIRST_ADDR;
                end else begin
                    dec_in_d  = cnt_q;
                    dec_en_d  = 1'b1;
                    wr_data_d = '0;
                    if (cnt_q == LAST_ADDR) begin
                        state_d = S_RUN;
                        busy_d  = 1'b0;
                        cnt_d   = FIRST_ADDR;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_RUN: begin
                if (clear_start) begin
                    state_d = S_CLEAR;
                    cnt_d   = FIRST_ADDR;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_CLEAR;
                cnt_d   = FIRST_ADDR;
                busy_d  = 1'b1;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            dec_in_q  <= '0;
            dec_en_q  <= 1'b0;
            wr_data_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            dec_in_q  <= dec_in_d;
            dec_en_q  <= dec_en_d;
            wr_data_q <= wr_data_d;
        end
    end

`ifdef REGFILE_ARB_CLEAR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_CLEAR;
            cnt_q   <= FIRST_ADDR;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end
`endif

    assign dec_in  = dec_in_q;
    assign dec_en  = dec_en_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter; clear-sweep checks need REGFILE_ARB_CLEAR_EN.
module tb_regfile_write_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned WIDTH = 32;

    typedef struct packed {
        logic        en;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*5-1:0]     req_addr;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_ready;
    logic                  clear_start;
    logic [4:0]            dec_in;
    logic                  dec_en;
    logic [WIDTH-1:0]      wr_data;
    logic                  busy;

    int   total;
    int   bad;
    bit   mon_en;
    int   m_ptr;
    logic [NREQ-1:0] last_grant;
    exp_t exp_q[$];

    regfile_write_arbiter #(
        .NREQ(NREQ),
        .WIDTH(WIDTH),
        .ZERO_REG(31)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_addr(req_addr),
        .req_data(req_data),
        .req_ready(req_ready),
        .clear_start(clear_start),
        .dec_in(dec_in),
        .dec_en(dec_en),
        .wr_data(wr_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] model_grant(input logic [NREQ-1:0] v, input int p);
        logic [NREQ-1:0] g;
        int idx;
        g = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (p + k) % NREQ;
            if (g == '0 && v[idx]) g[idx] = 1'b1;
        end
        return g;
    endfunction

    // Compare last cycle's prediction, then predict the write the coming edge produces.
    always @(negedge clk) begin
        exp_t e;
        exp_t ent;
        logic [NREQ-1:0] g;
        if (mon_en) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("dec_en", 64'(dec_en), 64'(e.en));
                if (e.en) begin
                    chk("dec_in", 64'(dec_in), 64'(e.addr));
                    chk("wr_data", 64'(wr_data), 64'(e.data));
                end
            end
            g = model_grant(req_valid, m_ptr);
            chk("ready", 64'(req_ready), 64'(g));
            last_grant = g;
            ent = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (g[i]) begin
                    ent.addr = req_addr[i*5 +: 5];
                    ent.data = req_data[i*WIDTH +: WIDTH];
                    ent.en   = (ent.addr != 5'd31);
                    m_ptr    = (i + 1) % NREQ;
                end
            end
            exp_q.push_back(ent);
        end
    end

    task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [4:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1);
        @(posedge clk);
        #1;
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    // Random requesters that keep a pending write stable until it is granted.
    task automatic drive_random(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            for (int r = 0; r < NREQ; r++) begin
                if (!req_valid[r] || last_grant[r]) begin
                    req_valid[r]              = 1'($urandom_range(0, 1));
                    req_addr[r*5 +: 5]        = 5'($urandom_range(0, 31));
                    req_data[r*WIDTH +: WIDTH] = $urandom;
                end
            end
        end
    endtask

    task automatic sweep_check(input bit drop_valid);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (dec_en) found = 1'b1;
        end
        chk("sweep_start", 64'(found), 64'd1);
        for (int i = 0; i < 31; i++) begin
            if (i != 0) @(negedge clk);
            chk("sweep_en", 64'(dec_en), 64'd1);
            chk("sweep_addr", 64'(dec_in), 64'(i));
            chk("sweep_data", 64'(wr_data), 64'd0);
            if (i < 30) chk("sweep_busy", 64'(busy), 64'd1);
            if (drop_valid && i < 20) chk("sweep_ready", 64'(req_ready), 64'd0);
            if (drop_valid && i == 20) req_valid = '0;
        end
        @(negedge clk);
        chk("sweep_end_en", 64'(dec_en), 64'd0);
        chk("sweep_end_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        bit found;
        total       = 0;
        bad         = 0;
        mon_en      = 1'b0;
        m_ptr       = 0;
        last_grant  = '0;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_addr    = '0;
        req_data    = '0;
        clear_start = 1'b0;

        #12;
        chk("rst_dec_en", 64'(dec_en), 64'd0);
        chk("rst_dec_in", 64'(dec_in), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
`ifdef REGFILE_ARB_CLEAR_EN
        chk("rst_busy", 64'(busy), 64'd1);
        req_valid = 2'b01;
        req_addr  = 10'd9;
`else
        chk("rst_busy", 64'(busy), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
`ifdef REGFILE_ARB_CLEAR_EN
        sweep_check(1'b1);
`endif

        @(posedge clk);
        #1;
        req_valid = '0;
        exp_q.delete();
        m_ptr  = 0;
        mon_en = 1'b1;

        drive(2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
        drive(2'b10, 5'd0, 5'd7, 32'h0, 32'h12345678);
        repeat (4) drive(2'b11, 5'd1, 5'd2, 32'h000000A1, 32'h000000B2);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        drive(2'b01, 5'd31, 5'd0, 32'hFFFF0000, 32'h0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        drive_random(80);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
        drive(2'b00, 5'd0, 5'd0, 32'h0, 32'h0);

`ifdef REGFILE_ARB_CLEAR_EN
        @(posedge clk);
        #1;
        mon_en      = 1'b0;
        req_valid   = 2'b01;
        req_addr    = 10'd3;
        clear_start = 1'b1;
        @(negedge clk);
        chk("clr_ready", 64'(req_ready), 64'd0);
        chk("clr_busy_pre", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        req_valid   = '0;
        sweep_check(1'b0);

        @(posedge clk);
        #1;
        clear_start = 1'b1;
        @(posedge clk);
        #1;
        clear_start = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (dec_en && dec_in == 5'd12) found = 1'b1;
        end
        chk("mid_sweep_12", 64'(found), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_dec_en", 64'(dec_en), 64'd0);
        chk("async_dec_in", 64'(dec_in), 64'd0);
        chk("async_wr_data", 64'(wr_data), 64'd0);
        chk("async_busy", 64'(busy), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        sweep_check(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
